// File: rtl/qspi_flash_pkg.sv
// Shared encodings and fixed phase lengths for the QSPI Fast Read Quad I/O block reader.
package qspi_flash_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StMode,
        StDummy,
        StData,
        StCsHigh
    } state_e;

    localparam logic [7:0] QSPI_CMD_FAST_READ_QUAD_IO = 8'hEB;
    localparam logic [7:0] QSPI_MODE_BYTE             = 8'hFF;

    localparam int unsigned CMD_CYCLES  = 8;
    localparam int unsigned ADDR_CYCLES = 6;
    localparam int unsigned MODE_CYCLES = 2;

    // Nibble idx of a 24-bit address, most significant nibble first.
    function automatic logic [3:0] addr_nibble(logic [23:0] addr, logic [2:0] idx);
        logic [4:0] base;
        base = 5'd20 - {idx[2:0], 2'b00};
        return addr[base+:4];
    endfunction

endpackage

// File: rtl/qspi_flash_block_reader_if.sv
// Fetch request, cache write port and flash pins of the QSPI block reader.
interface qspi_flash_block_reader_if #(
    parameter int unsigned ADDRESS_WIDTH = 22,
    parameter int unsigned BLOCK_SIZE    = 16
);
    localparam int unsigned IndexWidth = $clog2(BLOCK_SIZE);

    logic                     fetch_req;
    logic [ADDRESS_WIDTH-1:0] fetch_address;
    logic                     fetch_busy;
    logic                     fetch_done;
    logic                     wr_en;
    logic [IndexWidth-1:0]    wr_index;
    logic [31:0]              wr_data;
    logic                     rom_sck;
    logic [3:0]               rom_sio_out;
    logic [3:0]               rom_sio_oe;
    logic [3:0]               rom_sio_in;
    logic                     rom_ncs;

    modport master (
        input  fetch_req, fetch_address, rom_sio_in,
        output fetch_busy, fetch_done, wr_en, wr_index, wr_data,
        output rom_sck, rom_sio_out, rom_sio_oe, rom_ncs
    );

    modport slave (
        output fetch_req, fetch_address, rom_sio_in,
        input  fetch_busy, fetch_done, wr_en, wr_index, wr_data,
        input  rom_sck, rom_sio_out, rom_sio_oe, rom_ncs
    );

endinterface

// File: rtl/qspi_flash_block_reader_deser.sv
// Packs quad-I/O nibbles into little-endian 32-bit words (high nibble of each byte first).
module qspi_nibble_deserializer #(
    parameter int unsigned BLOCK_SIZE = 16,
    localparam int unsigned IndexWidth = $clog2(BLOCK_SIZE)
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  start_i,
    input  logic                  capture_i,
    input  logic [3:0]            sio_i,
    output logic                  wr_en_o,
    output logic [IndexWidth-1:0] wr_index_o,
    output logic [31:0]           wr_data_o
);
    logic [2:0]            nib_cnt_q, nib_cnt_d;
    logic [3:0]            hi_q, hi_d;
    logic [23:0]           part_q, part_d;
    logic [IndexWidth:0]   word_cnt_q, word_cnt_d;
    logic                  wr_en_q, wr_en_d;
    logic [IndexWidth-1:0] wr_index_q, wr_index_d;
    logic [31:0]           wr_data_q, wr_data_d;

    always_comb begin
        nib_cnt_d  = nib_cnt_q;
        hi_d       = hi_q;
        part_d     = part_q;
        word_cnt_d = word_cnt_q;
        wr_en_d    = 1'b0;
        wr_index_d = wr_index_q;
        wr_data_d  = wr_data_q;
        if (start_i) begin
            nib_cnt_d  = '0;
            word_cnt_d = '0;
        end else if (capture_i) begin
            nib_cnt_d = nib_cnt_q + 3'd1;
            // Completed bytes enter at the top so byte 0 ends up in bits [7:0].
            if (!nib_cnt_q[0]) hi_d = sio_i;
            else part_d = {hi_q, sio_i, part_q[23:8]};
            if (nib_cnt_q == 3'd7) begin
                wr_en_d    = 1'b1;
                wr_data_d  = {hi_q, sio_i, part_q};
                wr_index_d = word_cnt_q[IndexWidth-1:0];
                word_cnt_d = word_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            nib_cnt_q  <= '0;
            hi_q       <= '0;
            part_q     <= '0;
            word_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_index_q <= '0;
            wr_data_q  <= '0;
        end else begin
            nib_cnt_q  <= nib_cnt_d;
            hi_q       <= hi_d;
            part_q     <= part_d;
            word_cnt_q <= word_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_index_q <= wr_index_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign wr_en_o    = wr_en_q;
    assign wr_index_o = wr_index_q;
    assign wr_data_o  = wr_data_q;

endmodule

// File: rtl/qspi_flash_block_reader.sv
// Fast Read Quad I/O (0xEB) fetch engine: owns the flash pins and streams one cache block
// of 32-bit words into the cache data RAM, pulsing done with the last word.
module qspi_flash_block_reader
    import qspi_flash_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = 22,
    parameter int unsigned BLOCK_SIZE     = 16,
    parameter int unsigned DUMMY_CYCLES   = 4,
    parameter int unsigned CS_HIGH_CYCLES = 2
) (
    input logic                       clk,
    input logic                       nreset,
    qspi_flash_block_reader_if.master bus
);
    localparam int unsigned IndexWidth = $clog2(BLOCK_SIZE);
    localparam int unsigned DataCycles = 8 * BLOCK_SIZE;
    localparam int unsigned MaxA       = (DataCycles > DUMMY_CYCLES) ? DataCycles : DUMMY_CYCLES;
    localparam int unsigned MaxPhase   = (MaxA > CS_HIGH_CYCLES) ? MaxA : CS_HIGH_CYCLES;
    localparam int unsigned CntWidth   = $clog2(MaxPhase + 1);

    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [23:0]         addr_q, addr_d;
    logic                ncs_q, ncs_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [3:0]          oe_q, oe_d;
    logic [3:0]          out_q, out_d;
    logic                start;

    assign start = (state_q == StIdle) && bus.fetch_req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        addr_d  = addr_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (bus.fetch_req) begin
                    state_d = StCmd;
                    addr_d  = 24'({bus.fetch_address[ADDRESS_WIDTH-1:IndexWidth],
                                   {IndexWidth{1'b0}}, 2'b00});
                end
            end
            StCmd: if (cnt_q == CntWidth'(CMD_CYCLES - 1)) begin
                state_d = StAddr;
                cnt_d   = '0;
            end
            StAddr: if (cnt_q == CntWidth'(ADDR_CYCLES - 1)) begin
                state_d = StMode;
                cnt_d   = '0;
            end
            StMode: if (cnt_q == CntWidth'(MODE_CYCLES - 1)) begin
                state_d = StDummy;
                cnt_d   = '0;
            end
            StDummy: if (cnt_q == CntWidth'(DUMMY_CYCLES - 1)) begin
                state_d = StData;
                cnt_d   = '0;
            end
            StData: if (cnt_q == CntWidth'(DataCycles - 1)) begin
                state_d = StCsHigh;
                cnt_d   = '0;
            end
            StCsHigh: if (cnt_q == CntWidth'(CS_HIGH_CYCLES - 1)) begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: state_d = StIdle;
        endcase

        // Pin values are decoded from the state being entered so they register in phase.
        ncs_d  = 1'b1;
        busy_d = (state_d != StIdle);
        done_d = (state_q == StData) && (cnt_q == CntWidth'(DataCycles - 1));
        oe_d   = 4'h0;
        out_d  = 4'h0;
        unique case (state_d)
            StCmd: begin
                ncs_d = 1'b0;
                oe_d  = 4'b1101;
                out_d = {2'b11, 1'b0, QSPI_CMD_FAST_READ_QUAD_IO[~cnt_d[2:0]]};
            end
            StAddr: begin
                ncs_d = 1'b0;
                oe_d  = 4'hF;
                out_d = addr_nibble(addr_d, cnt_d[2:0]);
            end
            StMode: begin
                ncs_d = 1'b0;
                oe_d  = 4'hF;
                out_d = cnt_d[0] ? QSPI_MODE_BYTE[3:0] : QSPI_MODE_BYTE[7:4];
            end
            StDummy, StData: ncs_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            ncs_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            oe_q    <= 4'h0;
            out_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            ncs_q   <= ncs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            oe_q    <= oe_d;
            out_q   <= out_d;
        end
    end

    qspi_nibble_deserializer #(
        .BLOCK_SIZE(BLOCK_SIZE)
    ) u_deser (
        .clk       (clk),
        .nreset    (nreset),
        .start_i   (start),
        .capture_i (state_q == StData),
        .sio_i     (bus.rom_sio_in),
        .wr_en_o   (bus.wr_en),
        .wr_index_o(bus.wr_index),
        .wr_data_o (bus.wr_data)
    );

    assign bus.rom_ncs     = ncs_q;
    assign bus.rom_sck     = ~clk & ~ncs_q;
    assign bus.rom_sio_oe  = oe_q;
    assign bus.rom_sio_out = out_q;
    assign bus.fetch_busy  = busy_q;
    assign bus.fetch_done  = done_q;

endmodule

// File: tb/tb_qspi_flash_block_reader.sv
// Bench for qspi_flash_block_reader: default instance against a byte-pattern flash model,
// plus a DUMMY_CYCLES=8 / BLOCK_SIZE=4 instance for timing.
module tb_qspi_flash_block_reader;

    localparam int unsigned AW        = 22;
    localparam int unsigned BS        = 16;
    localparam int unsigned DC        = 4;
    localparam int unsigned CSH       = 2;
    localparam int          DataStart = 21;   // T+17+DUMMY_CYCLES
    localparam int          DoneC     = 149;  // T+21+8*16
    localparam int          BDataStart = 25;
    localparam int          BDoneC     = 57;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    qspi_flash_block_reader_if #(.ADDRESS_WIDTH(AW), .BLOCK_SIZE(BS)) bus ();
    qspi_flash_block_reader_if #(.ADDRESS_WIDTH(AW), .BLOCK_SIZE(4)) bus_b ();

    qspi_flash_block_reader #(
        .ADDRESS_WIDTH(AW), .BLOCK_SIZE(BS), .DUMMY_CYCLES(DC), .CS_HIGH_CYCLES(CSH)
    ) dut (
        .clk(clk), .nreset(nreset), .bus(bus)
    );

    qspi_flash_block_reader #(
        .ADDRESS_WIDTH(AW), .BLOCK_SIZE(4), .DUMMY_CYCLES(8), .CS_HIGH_CYCLES(CSH)
    ) dut_b (
        .clk(clk), .nreset(nreset), .bus(bus_b)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Flash content: byte at offset off of a transfer from addr.
    function automatic logic [7:0] exp_byte(input logic [23:0] addr, input int off);
        return 8'(off) ^ addr[7:0] ^ 8'h40;
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] addr, input int k);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b+:8] = exp_byte(addr, 4 * k + b);
        return w;
    endfunction

    // Flash model: sniffs command/address on rising SCK, drives data after falling SCK.
    int          sck_cnt = 0;
    logic [7:0]  sniff_cmd = '0;
    logic [23:0] sniff_addr = '0;
    int          nib;
    logic [7:0]  fbyte;

    always @(negedge clk) begin
        if (!bus.rom_ncs) begin
            if (sck_cnt < 8) sniff_cmd <= {sniff_cmd[6:0], bus.rom_sio_out[0]};
            else if (sck_cnt < 14) sniff_addr <= {sniff_addr[19:0], bus.rom_sio_out};
            sck_cnt <= sck_cnt + 1;
        end else begin
            sck_cnt <= 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (!bus.rom_ncs && sck_cnt >= 16 + DC) begin
            nib   = sck_cnt - 16 - DC;
            fbyte = exp_byte(sniff_addr, nib / 2);
            bus.rom_sio_in = (nib % 2 == 0) ? fbyte[7:4] : fbyte[3:0];
        end else begin
            bus.rom_sio_in = 4'h0;
        end
    end

    // Entered at the negedge of cycle T with the DUT idle; returns at the negedge of the
    // first cycle with busy low, which is the next T when req is held.
    task automatic run_fetch(input string tag, input logic [21:0] addr, input logic [23:0] exp_addr,
                             input logic [31:0] exp_first, input logic [31:0] exp_last,
                             input bit hold, input int pulse_at);
        int oe_err = 0, ncs_err = 0, busy_err = 0, time_err = 0, data_err = 0;
        int wr_cnt = 0, done_c = 0, done_cnt = 0;
        logic [31:0] first_w = '0, last_w = '0;
        logic [3:0] exp_oe;
        logic exp_ncs;
        bus.fetch_address = addr;
        bus.fetch_req = 1'b1;
        for (int c = 1; c <= DoneC + CSH; c++) begin
            @(negedge clk);
            if (c == 1) bus.fetch_req = hold;
            if (pulse_at != 0 && c == pulse_at) bus.fetch_req = 1'b1;
            if (pulse_at != 0 && c == pulse_at + 1) bus.fetch_req = 1'b0;
            exp_oe = (c <= 8) ? 4'b1101 : (c <= 16) ? 4'hF : 4'h0;
            if (bus.rom_sio_oe !== exp_oe) oe_err++;
            if (c <= 8 && bus.rom_sio_out[3:2] !== 2'b11) oe_err++;
            exp_ncs = (c >= DoneC);
            if (bus.rom_ncs !== exp_ncs || bus.rom_sck !== !exp_ncs) ncs_err++;
            if (bus.fetch_busy !== (c < DoneC + CSH)) busy_err++;
            if (bus.fetch_done === 1'b1) begin
                done_c = c;
                done_cnt++;
            end
            if (bus.wr_en === 1'b1) begin
                if (c != DataStart + 8 * (wr_cnt + 1)) time_err++;
                if (bus.wr_index !== 4'(wr_cnt)) data_err++;
                if (bus.wr_data !== exp_word(exp_addr, wr_cnt)) data_err++;
                if (wr_cnt == 0) first_w = bus.wr_data;
                last_w = bus.wr_data;
                wr_cnt++;
            end
        end
        check({tag, " cmd_byte"}, 32'(sniff_cmd), 32'h0000_00EB);
        check({tag, " addr_issued"}, 32'(sniff_addr), 32'(exp_addr));
        check({tag, " oe_errors"}, oe_err, 0);
        check({tag, " ncs_sck_errors"}, ncs_err, 0);
        check({tag, " busy_errors"}, busy_err, 0);
        check({tag, " wr_count"}, wr_cnt, BS);
        check({tag, " wr_timing_errors"}, time_err, 0);
        check({tag, " data_index_errors"}, data_err, 0);
        check({tag, " first_word"}, first_w, exp_first);
        check({tag, " last_word"}, last_w, exp_last);
        check({tag, " done_cycle"}, done_c, DoneC);
        check({tag, " done_pulses"}, done_cnt, 1);
    endtask

    typedef struct {
        logic [21:0] addr;
        logic [23:0] byte_addr;
        logic [31:0] first_word;
        logic [31:0] last_word;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int err;
        vecs[0] = '{22'h000010, 24'h000040, 32'h0302_0100, 32'h3F3E_3D3C};
        vecs[1] = '{22'h00001F, 24'h000040, 32'h0302_0100, 32'h3F3E_3D3C};
        vecs[2] = '{22'h000000, 24'h000000, 32'h4342_4140, 32'h7F7E_7D7C};
        vecs[3] = '{22'h3FFFFF, 24'hFFFFC0, 32'h8382_8180, 32'hBFBE_BDBC};
        vecs[4] = '{22'h002A6B, 24'h00A980, 32'hC3C2_C1C0, 32'hFFFE_FDFC};

        bus.fetch_req = 1'b0;
        bus.fetch_address = '0;
        bus_b.fetch_req = 1'b0;
        bus_b.fetch_address = '0;
        bus_b.rom_sio_in = 4'hA;

        repeat (3) @(negedge clk);
        check("rst ncs", 32'(bus.rom_ncs), 1);
        check("rst oe", 32'(bus.rom_sio_oe), 0);
        check("rst sio_out", 32'(bus.rom_sio_out), 0);
        check("rst busy", 32'(bus.fetch_busy), 0);
        check("rst done", 32'(bus.fetch_done), 0);
        check("rst wr_en", 32'(bus.wr_en), 0);
        check("rst wr_index", 32'(bus.wr_index), 0);
        check("rst wr_data", bus.wr_data, 0);
        check("rst sck", 32'(bus.rom_sck), 0);
        nreset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].byte_addr,
                      vecs[i].first_word, vecs[i].last_word, 1'b0, 0);
        end

        // Held req: second CMD must begin the cycle after busy falls (checked at its c=1).
        run_fetch("held1", vecs[0].addr, vecs[0].byte_addr, vecs[0].first_word,
                  vecs[0].last_word, 1'b1, 0);
        run_fetch("held2", vecs[2].addr, vecs[2].byte_addr, vecs[2].first_word,
                  vecs[2].last_word, 1'b0, 0);

        // Req pulsed mid-fetch must not queue a second transaction.
        run_fetch("pulse", vecs[0].addr, vecs[0].byte_addr, vecs[0].first_word,
                  vecs[0].last_word, 1'b0, 60);
        err = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.rom_ncs !== 1'b1 || bus.fetch_busy !== 1'b0 || bus.wr_en !== 1'b0) err++;
        end
        check("pulse ignored", err, 0);

        // Reset in the middle of DATA.
        bus.fetch_address = vecs[0].addr;
        bus.fetch_req = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) bus.fetch_req = 1'b0;
        end
        nreset = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        check("abort ncs", 32'(bus.rom_ncs), 1);
        check("abort oe", 32'(bus.rom_sio_oe), 0);
        check("abort busy", 32'(bus.fetch_busy), 0);
        check("abort wr_en", 32'(bus.wr_en), 0);
        err = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.wr_en !== 1'b0 || bus.rom_ncs !== 1'b1 || bus.fetch_done !== 1'b0) err++;
        end
        check("abort quiet", err, 0);
        run_fetch("after_abort", vecs[1].addr, vecs[1].byte_addr, vecs[1].first_word,
                  vecs[1].last_word, 1'b0, 0);

        // DUMMY_CYCLES=8, BLOCK_SIZE=4 instance; flash drives a constant 0xA nibble.
        begin
            int wr_cnt = 0, time_err = 0, data_err = 0, ncs_err = 0, done_c = 0;
            bus_b.fetch_req = 1'b1;
            for (int c = 1; c <= 70; c++) begin
                @(negedge clk);
                if (c == 1) bus_b.fetch_req = 1'b0;
                if (bus_b.rom_ncs !== (c >= BDoneC)) ncs_err++;
                if (bus_b.fetch_done === 1'b1) done_c = c;
                if (bus_b.wr_en === 1'b1) begin
                    if (c != BDataStart + 8 * (wr_cnt + 1)) time_err++;
                    if (bus_b.wr_index !== 2'(wr_cnt)) data_err++;
                    if (bus_b.wr_data !== 32'hAAAA_AAAA) data_err++;
                    wr_cnt++;
                end
            end
            check("b wr_count", wr_cnt, 4);
            check("b wr_timing_errors", time_err, 0);
            check("b data_errors", data_err, 0);
            check("b ncs_errors", ncs_err, 0);
            check("b done_cycle", done_c, BDoneC);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qspi_flash_block_reader.md
Name: qspi_flash_block_reader

Overview:
- Downstream fetch engine for the QSPI ROM cache. On a cache miss it reads one cache block from the QSPI NOR flash.
- Uses Fast Read Quad I/O, command 0xEB: command in 1-bit mode, address/mode in 4-bit mode, dummy clocks, then 4-bit data.
- Streams 32-bit words to the cache data RAM through a write port, then pulses done.
- Sole owner of the flash pins.

Parameters:
- ADDRESS_WIDTH, 22, word address width; ADDRESS_WIDTH+2 <= 24, byte address zero-extended to 24 bits.
- BLOCK_SIZE, 16, words per fetch; power of two >= 2.
- DUMMY_CYCLES, 4, dummy SCK cycles after mode byte; >= 1.
- CS_HIGH_CYCLES, 2, minimum cycles ncs stays high after a transaction; >= 1.

Ports:
- clk  in  1  system clock.
- nreset  in  1  synchronous active-low reset.
- fetch_req  in  1  start a block fetch; sampled only in IDLE.
- fetch_address  in  ADDRESS_WIDTH  word address; low log2(BLOCK_SIZE) bits ignored (block aligned).
- fetch_busy  out  1  high from the cycle after acceptance until the CS-high gap ends.
- fetch_done  out  1  one-cycle pulse, coincident with the last wr_en.
- wr_en  out  1  word write strobe, one cycle per word.
- wr_index  out  log2(BLOCK_SIZE)  word offset within block, 0..BLOCK_SIZE-1 ascending.
- wr_data  out  32  assembled word.
- rom_sck  out  1  = !clk while rom_ncs low, else 0.
- rom_sio_out  out  4  IO3..IO0 drive values.
- rom_sio_oe  out  4  per-line output enable.
- rom_sio_in  in  4  IO3..IO0 sampled values.
- rom_ncs  out  1  flash chip select, active low.

Behaviour:
- Reset, sync, active-low, clk: state IDLE, rom_ncs=1, rom_sio_oe=0, rom_sio_out=0, fetch_busy=0, fetch_done=0, wr_en=0, wr_index=0, wr_data=0.
- Reset in any state aborts immediately: ncs high next edge, no further wr_en.
- All outputs are registered on posedge clk. The flash samples on rising SCK (clk falling). rom_sio_in is captured on posedge clk.
- States: IDLE, CMD, ADDR, MODE, DUMMY, DATA, CSHIGH. Transitions are unconditional once a phase counter expires.
- IDLE: on fetch_req=1 (cycle T), latch {fetch_address block bits, zeros, 2'b00} as the 24-bit byte address. Then ncs=0, busy=1, enter CMD at T+1. fetch_req is ignored outside IDLE.
- CMD: 8 cycles (T+1..T+8), 0xEB MSB first on IO0.
  - oe=4'b1101, IO3=IO2=1 (HOLD#/WP# inactive), IO1 not driven.
- ADDR: 6 cycles (T+9..T+14), oe=4'hF, address nibbles MSB first.
- MODE: 2 cycles, oe=4'hF, nibbles F,F (no continuous-read mode).
- DUMMY: DUMMY_CYCLES cycles, oe=0.
- DATA: 8*BLOCK_SIZE cycles, oe=0. Starts at T+17+DUMMY_CYCLES (T+21 at default).
  - One nibble is captured at the posedge ending each DATA cycle.
  - Byte order little-endian: first byte goes to bits [7:0]. Within a byte, the high nibble comes first.
- Word k is complete after its 8th nibble. wr_en=1 with wr_data/wr_index=k in the following cycle.
  - Default: word 0 written at T+29, word 15 at T+149.
- The last word's wr_en coincides with fetch_done=1 and ncs=1 (T+149 default). The state enters CSHIGH.
- CSHIGH: ncs=1 for CS_HIGH_CYCLES cycles including the done cycle. busy=0 after that; IDLE accepts a new req in the first cycle busy=0.
- A fetch_req held high continuously starts a new fetch as soon as IDLE is reached. There is no queueing.
- Nibble and word counters are wide enough for 8*BLOCK_SIZE with no wrap. wr_index wraps to 0 only on a new fetch.

Decomposition:
- Package qspi_flash_pkg holds:
  - state encoding;
  - QSPI_CMD_FAST_READ_QUAD_IO=8'hEB;
  - QSPI_MODE_BYTE=8'hFF;
  - CMD_CYCLES=8, ADDR_CYCLES=6, MODE_CYCLES=2.
- Sub-module qspi_nibble_deserializer is natural: nibble shift into a 32-bit word, byte/nibble ordering, word-complete strobe.

Test Plan:
- Reset mid-DATA (assert nreset at T+40) -> next edge ncs=1, oe=0, busy=0; no further wr_en; new req afterwards fetches correctly.
- Flash model with bytes 00,01,02,...; req with fetch_address=0x000010 at T -> address nibbles 000040 on IO; words 0x03020100..0x3F3E3D3C at wr_index 0..15; first wr_en at T+29; done and last wr_en at T+149.
- Command/mode check: sniff IO0 at rising SCK in CMD = 1,1,1,0,1,0,1,1. oe=1101 in CMD, 1111 in ADDR/MODE, 0000 otherwise. IO3/IO2 high during CMD.
- fetch_address=0x00001F (misaligned) -> byte address 0x000040 issued; identical data to the aligned case.
- fetch_req held high across two fetches -> ncs high exactly CS_HIGH_CYCLES cycles between transactions; second CMD starts the cycle after busy falls. Pulsing req while busy -> ignored.
- DUMMY_CYCLES=8, BLOCK_SIZE=4 -> DATA starts at T+25; exactly 4 wr_en; done at T+25+32.
